// File: rtl/pipeline_skid_stage.sv
// Elastic valid/ready register stage with a two-entry buffer (output register plus skid register).
// ENABLE=0 reduces the stage to a combinational wire-through with no storage.
module pipeline_skid_stage #(
    parameter int WIDTH  = 32,
    parameter bit ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    generate
        if (ENABLE) begin : g_skid
            localparam logic [1:0] ST_EMPTY = 2'd0;
            localparam logic [1:0] ST_BUSY  = 2'd1;
            localparam logic [1:0] ST_FULL  = 2'd2;

            logic [1:0]       state;
            logic [1:0]       state_next;
            logic [WIDTH-1:0] out_reg;
            logic [WIDTH-1:0] out_next;
            logic [WIDTH-1:0] skid_reg;
            logic [WIDTH-1:0] skid_next;
            logic             in_fire;
            logic             out_fire;

            // Handshake outputs come only from the state register, so out_ready never reaches in_ready.
            // The unused encoding neither accepts nor presents data while it recovers.
            always_comb begin
                in_ready  = (state == ST_EMPTY) || (state == ST_BUSY);
                out_valid = (state == ST_BUSY) || (state == ST_FULL);
                out_data  = out_reg;
                case (state)
                    ST_BUSY: occupancy = 2'd1;
                    ST_FULL: occupancy = 2'd2;
                    default: occupancy = 2'd0;
                endcase
            end

            assign in_fire  = in_valid && in_ready;
            assign out_fire = out_valid && out_ready;

            always_comb begin
                state_next = state;
                out_next   = out_reg;
                skid_next  = skid_reg;
                case (state)
                    ST_EMPTY: begin
                        if (in_fire) begin
                            out_next   = in_data;
                            state_next = ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        if (in_fire && out_fire) begin
                            out_next = in_data;
                        end else if (in_fire) begin
                            skid_next  = in_data;
                            state_next = ST_FULL;
                        end else if (out_fire) begin
                            state_next = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (out_fire) begin
                            out_next   = skid_reg;
                            state_next = ST_BUSY;
                        end
                    end
                    default: begin
                        state_next = ST_EMPTY;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state    <= ST_EMPTY;
                    out_reg  <= '0;
                    skid_reg <= '0;
                end else begin
                    state    <= state_next;
                    out_reg  <= out_next;
                    skid_reg <= skid_next;
                end
            end
        end else begin : g_wire
            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign in_ready  = out_ready;
            assign occupancy = 2'd0;
        end
    endgenerate

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Scoreboard bench for pipeline_skid_stage: directed vectors, a random valid/ready soak,
// and a second instance built with ENABLE=0 to check the wire-through mode.
module tb_pipeline_skid_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [31:0] w_in_data;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_data;
    logic [1:0]  w_occupancy;

    int tests_run;
    int tests_failed;
    logic [31:0] exp_q[$];

    logic        prev_stall;
    logic [31:0] prev_data;

    pipeline_skid_stage #(.WIDTH(32), .ENABLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipeline_skid_stage #(.WIDTH(32), .ENABLE(1'b0)) dut_wire (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .occupancy(w_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Inputs change just after a rising edge; the accepted word is queued at the following falling edge.
    task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        if (rst_n && in_valid && in_ready) exp_q.push_back(in_data);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check_output("stall_valid", {31'd0, out_valid}, 32'd1);
                check_output("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("underflow", out_data, 32'hFFFF_FFFF ^ out_data);
                end else begin
                    check_output("sb_data", out_data, exp_q.pop_front());
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        pend_v;
        logic [31:0] pend_d;
        logic        v;
        logic [31:0] d;
        logic [1:0]  tv;

        tests_run    = 0;
        tests_failed = 0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        w_in_valid   = 1'b0;
        w_in_data    = '0;
        w_out_ready  = 1'b0;

        #12;
        check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("rst_occupancy", {30'd0, occupancy}, 32'd0);
        check_output("rst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming 1..8 with downstream always ready
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b1, i, 1'b1);
            if (i > 1) begin
                check_output("stream_occ", {30'd0, occupancy}, 32'd1);
                check_output("stream_in_ready", {31'd0, in_ready}, 32'd1);
                check_output("stream_data", out_data, i - 1);
            end
        end
        apply_stimulus(1'b0, 32'd0, 1'b1);
        check_output("stream_last", out_data, 32'd8);
        apply_stimulus(1'b0, 32'd0, 1'b1);
        check_output("stream_empty_occ", {30'd0, occupancy}, 32'd0);

        // Back-pressure fills both entries, then drains in order
        apply_stimulus(1'b1, 32'hA, 1'b0);
        apply_stimulus(1'b1, 32'hB, 1'b0);
        check_output("bp_busy_data", out_data, 32'hA);
        apply_stimulus(1'b1, 32'hC, 1'b0);
        check_output("bp_full_occ", {30'd0, occupancy}, 32'd2);
        check_output("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        check_output("bp_full_data", out_data, 32'hA);
        apply_stimulus(1'b0, 32'd0, 1'b1);
        apply_stimulus(1'b0, 32'd0, 1'b1);
        check_output("bp_second", out_data, 32'hB);
        check_output("bp_in_ready", {31'd0, in_ready}, 32'd1);
        apply_stimulus(1'b0, 32'd0, 1'b1);
        check_output("empty_occ", {30'd0, occupancy}, 32'd0);
        check_output("empty_retain", out_data, 32'hB);
        check_output("empty_valid", {31'd0, out_valid}, 32'd0);

        // Simultaneous in/out transfer while BUSY
        apply_stimulus(1'b1, 32'h5, 1'b0);
        apply_stimulus(1'b0, 32'd0, 1'b0);
        check_output("sim_hold", out_data, 32'h5);
        apply_stimulus(1'b1, 32'h6, 1'b1);
        apply_stimulus(1'b0, 32'd0, 1'b0);
        check_output("sim_data", out_data, 32'h6);
        check_output("sim_occ", {30'd0, occupancy}, 32'd1);
        apply_stimulus(1'b0, 32'd0, 1'b1);
        apply_stimulus(1'b0, 32'd0, 1'b0);
        check_output("sim_empty", {30'd0, occupancy}, 32'd0);

        // Asynchronous reset while FULL, asserted mid-cycle
        apply_stimulus(1'b1, 32'h11, 1'b0);
        apply_stimulus(1'b1, 32'h22, 1'b0);
        apply_stimulus(1'b0, 32'd0, 1'b0);
        check_output("pre_rst_occ", {30'd0, occupancy}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("arst_occ", {30'd0, occupancy}, 32'd0);
        check_output("arst_out_data", out_data, 32'd0);
        check_output("arst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random soak; upstream holds its word until accepted
        pend_v = 1'b0;
        pend_d = '0;
        for (int i = 0; i < 10000; i++) begin
            if (pend_v) begin
                v = 1'b1;
                d = pend_d;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                d = $urandom;
            end
            apply_stimulus(v, d, ($urandom_range(0, 2) != 0));
            pend_v = in_valid && !in_ready;
            pend_d = in_data;
            check_output("rand_in_ready", {31'd0, in_ready}, {31'd0, occupancy != 2'd2});
        end
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
            apply_stimulus(1'b0, 32'd0, 1'b1);
        end
        apply_stimulus(1'b0, 32'd0, 1'b1);
        check_output("drain", exp_q.size(), 32'd0);

        // Wire-through instance mirrors its inputs combinationally
        for (int i = 0; i < 4; i++) begin
            tv          = i[1:0];
            w_in_valid  = tv[0];
            w_out_ready = tv[1];
            w_in_data   = tv[0] ? 32'hDEADBEEF : 32'h0;
            #1;
            check_output("wire_valid", {31'd0, w_out_valid}, {31'd0, tv[0]});
            check_output("wire_ready", {31'd0, w_in_ready}, {31'd0, tv[1]});
            check_output("wire_data", w_out_data, tv[0] ? 32'hDEADBEEF : 32'h0);
            check_output("wire_occ", {30'd0, w_occupancy}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_skid_stage.md
Name: pipeline_skid_stage

Overview:
- Elastic, valid/ready-handshaked register stage; the flow-controlled counterpart of the plain pipeline register stage.
- Sits directly upstream of the free-running pipeline stages. It absorbs downstream back-pressure so retimed datapaths can stall without dropping data.
- Provides a 2-entry buffer: an output register plus a skid register.
  - Full throughput: 1 transfer/cycle.
  - All outputs registered, so no combinational path from out_ready to in_ready.
- ENABLE=0 collapses it to a wire-through for retiming experiments.

Parameters:
- WIDTH, 32, data bus width in bits.
- ENABLE, 1: 1 = registered skid stage; 0 = combinational pass-through (no storage).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset (asserts immediately, deasserts synchronously to clk by upstream reset synchroniser).
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage can accept data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  registered output data.
- occupancy  output  2  number of entries held (0..2).

Behaviour:
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Both are sampled at posedge clk.
- Reset (rst_n low, asynchronous):
  - state=EMPTY, out_valid=0, out_data=0, skid register=0, occupancy=0, in_ready=1.
  - No transfer is recorded while rst_n is low.
  - Reset mid-stream discards all held data.
- State machine (ENABLE=1):
  - EMPTY (occ 0): in_fire -> out reg <= in_data, go to BUSY.
  - BUSY (occ 1):
    - in_fire & out_fire -> out reg <= in_data, stay BUSY.
    - in_fire & !out_fire -> skid <= in_data, go to FULL.
    - !in_fire & out_fire -> go to EMPTY.
    - Otherwise hold.
  - FULL (occ 2): out_fire -> out reg <= skid, go to BUSY. Otherwise hold.
- Output decode (from state registers only):
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - occupancy = 0/1/2 for EMPTY/BUSY/FULL.
- Latency: data accepted at edge N appears on out_data with out_valid=1 after edge N (1 cycle).
- Ordering: strict FIFO; no data dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_valid and out_data hold unchanged.
- FULL with in_valid high: in_ready=0 and the input is ignored. Upstream must hold its data (protocol obligation, not checked).
- EMPTY with out_ready high: no output transfer; out_data retains its last value.
- Illegal state encoding: recovers to EMPTY.
- ENABLE=0 (combinational, no registers):
  - out_valid = in_valid, out_data = in_data, in_ready = out_ready, occupancy = 0.
  - rst_n has no effect.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with FULL stage -> out_valid=0, occupancy=0, out_data=0, in_ready=1 immediately, without waiting for a clock edge.
- Streaming: out_ready=1, send 0x1..0x8 back-to-back -> out_data 0x1..0x8 each one cycle later, in_ready=1 throughout, occupancy=1 steady.
- Back-pressure: send 0xA, 0xB with out_ready=0 -> occupancy reaches 2, in_ready=0, out_data holds 0xA. Raise out_ready -> 0xA then 0xB delivered in order, in_ready=1 again.
- Simultaneous in/out fire in BUSY: hold 0x5, present 0x6 with out_ready=1 -> next cycle out_data=0x6, occupancy=1.
- Random valid/ready (10k cycles, scoreboard): no loss, duplication or reorder; out_data stable under stall; in_ready never low except in FULL.
- ENABLE=0: toggle in_valid/out_ready/in_data=0xDEADBEEF -> outputs mirror inputs in the same cycle, occupancy=0.
